// File: rtl/axi_wr_burst_gate.sv
// axi_wr_burst_gate: holds each AW until its full W burst is buffered and caps AWs awaiting B
module axi_wr_burst_gate #(
  parameter int MAX_BURSTS      = 32,
  parameter int MAX_OUTSTANDING = 16,
  parameter int BURST_CNT_WIDTH = $clog2(MAX_BURSTS + 1),
  parameter int OUTST_CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       wfifo_push,
  input  logic                       wfifo_push_last,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  input  logic                       m_axi_bvalid,
  input  logic                       m_axi_bready,
  output logic [BURST_CNT_WIDTH-1:0] burst_count,
  output logic [OUTST_CNT_WIDTH-1:0] outstanding_count,
  output logic                       err
);
  logic aw_hold, permit, aw_issue, b_done, last_in;
  // aw_hold keeps a presented AW valid even if enable drops before it is accepted
  assign permit = aw_hold | (enable & (burst_count != '0) &
                  (outstanding_count < OUTST_CNT_WIDTH'(MAX_OUTSTANDING)));
  assign m_axi_awvalid = s_axi_awvalid & permit;
  assign s_axi_awready = m_axi_awready & permit;
  assign aw_issue = m_axi_awvalid & m_axi_awready;
  assign b_done = m_axi_bvalid & m_axi_bready;
  assign last_in = wfifo_push & wfifo_push_last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      burst_count <= '0;
      outstanding_count <= '0;
      err <= 1'b0;
      aw_hold <= 1'b0;
    end else begin
      aw_hold <= aw_issue ? 1'b0 : aw_hold | (m_axi_awvalid & ~m_axi_awready);
      if (last_in & ~aw_issue) begin
        if (burst_count == BURST_CNT_WIDTH'(MAX_BURSTS)) err <= 1'b1;
        else burst_count <= burst_count + BURST_CNT_WIDTH'(1);
      end else if (aw_issue & ~last_in) burst_count <= burst_count - BURST_CNT_WIDTH'(1);
      if (b_done & ~aw_issue) begin
        if (outstanding_count == '0) err <= 1'b1;
        else outstanding_count <= outstanding_count - OUTST_CNT_WIDTH'(1);
      end else if (aw_issue & ~b_done) outstanding_count <= outstanding_count + OUTST_CNT_WIDTH'(1);
    end
endmodule
